voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Note-event front end for the FM voice matrix.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to one of NUM_VOICES voices.
- Drives per-voice Trig pulses and held noteOff levels into the ADSRenv instances, and frees voices using each envelope's idle feedback.
- Exposes per-voice note/velocity for pitch and level lookup downstream.

Parameters:
- NUM_VOICES, 8, number of voices and envelopes driven (2..16).
- NOTE_W, 7, note number width (MIDI).
- VEL_W, 7, velocity width.
- AGE_W, 8, per-voice saturating age counter width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- evValid  in  1  event present
- evReady  out  1  allocator can accept an event
- evNoteOn  in  1  1 = note-on, 0 = note-off
- evNote  in  NOTE_W  note number
- evVel  in  VEL_W  velocity; note-on with velocity 0 is treated as note-off
- envIdle  in  NUM_VOICES  per-voice level, high while that envelope is idle
- Trig  out  NUM_VOICES  one-cycle retrigger pulse per voice
- noteOff  out  NUM_VOICES  held release request per voice
- voiceActive  out  NUM_VOICES  voice allocated
- voiceNote  out  NUM_VOICES*NOTE_W  packed per-voice note, voice v at [v*NOTE_W +: NOTE_W]
- voiceVel  out  NUM_VOICES*VEL_W  packed per-voice velocity
- stolen  out  1  one-cycle pulse, coincident with Trig, when an active non-releasing voice was taken

Behaviour:
- Reset values:
  - All outputs 0, including evReady.
  - All ages 0; FSM in IDLE.
  - evReady rises the first cycle after Reset deasserts.
- Reset mid-scan: the latched event is discarded, no Trig is issued, and the FSM returns to IDLE.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: evReady=1. When evValid&evReady, latch the event, set scanIdx=0, go to SCAN.
  - SCAN: evReady=0. Examine voice scanIdx, one per cycle, for NUM_VOICES cycles, updating candidate registers. After scanIdx=NUM_VOICES-1, go to COMMIT.
  - COMMIT: apply the decision to the registered outputs, go to IDLE.
- Latency: for an event accepted at edge t, Trig/noteOff changes are visible at cycle t+NUM_VOICES+2, and evReady is high again in that same cycle. Throughput is one event per NUM_VOICES+2 cycles.
- Note-on priority (ties resolved to lowest index):
  1. match: voiceActive[v] and voiceNote[v]==evNote, regardless of noteOff; the voice is retriggered.
  2. lowest-index voice with ~voiceActive.
  3. oldest releasing voice (noteOff[v]=1).
  4. oldest active voice; this case pulses stolen.
- Note-on commit on chosen voice v:
  - Trig[v]=1 for exactly one cycle.
  - noteOff[v]=0, voiceActive[v]=1.
  - Load note and velocity.
  - age[v]=0.
  - Every other active voice increments its age, saturating at 2^AGE_W-1. Larger age = older.
- Note-off (including velocity-0 note-on):
  - Target is the lowest-index voice with voiceActive, noteOff=0, and a matching note; set noteOff[v]=1 at commit.
  - No match: the event is consumed and no output changes.
  - Ages are unchanged.
- Voice free:
  - At any cycle where voiceActive[v] & noteOff[v] & envIdle[v] & ~Trig[v], the next cycle clears voiceActive[v] and noteOff[v].
  - voiceNote and voiceVel hold their last values.
  - Freeing runs concurrently with SCAN.
  - If a free and a COMMIT on the same voice coincide, COMMIT wins.
- Envelope idles without a note-off (sustain timeout): the voice stays active until its note-off arrives, then frees on the next envIdle.
- noteOff[v] stays high until the voice is freed or retriggered; the envelope samples it as a level.
- evValid deasserting while evReady=0 has no effect; the latched event completes.

Decomposition:
- Package synth_pkg:
  - NOTE_W, VEL_W, AGE_W defaults.
  - alloc_state_t enum {IDLE, SCAN, COMMIT}.
  - AGE_MAX constant.
- Sub-module voice_slot, instantiated NUM_VOICES times:
  - Holds active, noteOff, note, vel, age.
  - Implements the free condition and age saturation.
  - Inputs: commit/select/kind strobes and envIdle.
- The top holds the FSM, scan index, and candidate registers (match, free, oldest-releasing, oldest-active, with their ages).

Test Plan:
- NUM_VOICES=4, reset, then note-on 60/vel 100 accepted at cycle 5 -> Trig=4'b0001 only in cycle 11, voiceNote[0]=60, voiceVel[0]=100, evReady low in cycles 6-10.
- Note-ons 60,62,64,66 then 67, no releases -> 67 steals voice 0 (age 3, oldest), stolen=1 with Trig=4'b0001, voiceNote[0]=67.
- Note-on 60 then note-off 60 -> noteOff[0]=1 held; envIdle[0]=0 then raised 20 cycles later -> voiceActive[0] and noteOff[0] clear the next cycle.
- With 4 voices active and voice 2 releasing, note-on 70 -> voice 2 chosen, noteOff[2] cleared, stolen=0.
- Note-on 60 twice -> second retriggers voice 0 (Trig=4'b0001 again), voice 1 stays inactive; note-on 61 with velocity 0 when 61 is not playing -> no output change, evReady returns after 6 cycles.
- Reset asserted during SCAN of a note-on -> no Trig, all outputs 0, evReady=1 the cycle after Reset drops.

Source files
------------

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared types and default widths for the voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_NOTE_W     = 7;
    localparam int DEF_VEL_W      = 7;
    localparam int DEF_AGE_W      = 8;

    // Saturation value of the age counter at its default width.
    localparam int AGE_MAX = (1 << DEF_AGE_W) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/voice_slot.sv
`default_nettype none
// ============================================================================
// Module      : voice_slot
// Description : Per-voice state: allocation, release request, note, velocity,
//               saturating age, retrigger pulse and envelope-driven freeing.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_slot
    import synth_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int VEL_W  = DEF_VEL_W,
    parameter int AGE_W  = DEF_AGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_on,
    input  logic              commit_off,
    input  logic              age_inc,
    input  logic              env_idle,
    input  logic [NOTE_W-1:0] ev_note,
    input  logic [VEL_W-1:0]  ev_vel,
    output logic              trig,
    output logic              active,
    output logic              note_off,
    output logic [NOTE_W-1:0] note,
    output logic [VEL_W-1:0]  vel,
    output logic [AGE_W-1:0]  age
);

    localparam logic [AGE_W-1:0] AGE_LIMIT = '1;

    logic free_now;

    // A released voice whose envelope has gone idle is returned to the pool.
    assign free_now = active & note_off & env_idle & ~trig;

    // Slot state update; a note-on commit overrides a coincident free.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig     <= 1'b0;
            active   <= 1'b0;
            note_off <= 1'b0;
            note     <= '0;
            vel      <= '0;
            age      <= '0;
        end else begin
            trig <= commit_on;
            if (commit_on) begin
                active   <= 1'b1;
                note_off <= 1'b0;
                note     <= ev_note;
                vel      <= ev_vel;
                age      <= '0;
            end else begin
                if (commit_off) begin
                    note_off <= 1'b1;
                end else if (free_now) begin
                    active   <= 1'b0;
                    note_off <= 1'b0;
                end
                if (age_inc && active && (age != AGE_LIMIT)) begin
                    age <= age + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Note-event front end; scans all voices serially for each
//               event, then retriggers, allocates, steals or releases one.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int VEL_W      = DEF_VEL_W,
    parameter int AGE_W      = DEF_AGE_W
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       evValid,
    output logic                       evReady,
    input  logic                       evNoteOn,
    input  logic [NOTE_W-1:0]          evNote,
    input  logic [VEL_W-1:0]           evVel,
    input  logic [NUM_VOICES-1:0]      envIdle,
    output logic [NUM_VOICES-1:0]      Trig,
    output logic [NUM_VOICES-1:0]      noteOff,
    output logic [NUM_VOICES-1:0]      voiceActive,
    output logic [NUM_VOICES*NOTE_W-1:0] voiceNote,
    output logic [NUM_VOICES*VEL_W-1:0]  voiceVel,
    output logic                       stolen
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t state, next_state;

    logic [IDX_W-1:0]  scan_idx;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [VEL_W-1:0]  ev_vel;

    logic              match_found, free_found, rel_found, act_found;
    logic [IDX_W-1:0]  match_idx, free_idx, rel_idx, act_idx;
    logic [AGE_W-1:0]  rel_age, act_age;

    logic [NOTE_W-1:0] notes [NUM_VOICES];
    logic [AGE_W-1:0]  ages  [NUM_VOICES];

    logic [NUM_VOICES-1:0] commit_on_vec, commit_off_vec;
    logic [IDX_W-1:0]      chosen;
    logic                  steal;

    logic              accept;
    logic              cur_active, cur_off;
    logic [NOTE_W-1:0] cur_note;
    logic [AGE_W-1:0]  cur_age;

    assign accept     = evValid & evReady;
    assign cur_active = voiceActive[scan_idx];
    assign cur_off    = noteOff[scan_idx];
    assign cur_note   = notes[scan_idx];
    assign cur_age    = ages[scan_idx];

    // State register; evReady is registered so it stays low through reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            evReady <= 1'b0;
            stolen  <= 1'b0;
        end else begin
            state   <= next_state;
            evReady <= (next_state == IDLE);
            stolen  <= steal;
        end
    end

    // Next-state logic for the accept / scan / commit sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Event latch and serial candidate search, one voice per SCAN cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            scan_idx    <= '0;
            ev_on       <= 1'b0;
            ev_note     <= '0;
            ev_vel      <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            act_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            rel_idx     <= '0;
            act_idx     <= '0;
            rel_age     <= '0;
            act_age     <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                scan_idx    <= '0;
                ev_on       <= evNoteOn & (evVel != '0);
                ev_note     <= evNote;
                ev_vel      <= evVel;
                match_found <= 1'b0;
                free_found  <= 1'b0;
                rel_found   <= 1'b0;
                act_found   <= 1'b0;
            end
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            // Note-off only targets voices not already releasing.
            if (!match_found && cur_active && (cur_note == ev_note) && (ev_on || !cur_off)) begin
                match_found <= 1'b1;
                match_idx   <= scan_idx;
            end
            if (!free_found && !cur_active) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
            // Strictly-greater comparison keeps the lowest index on age ties.
            if (cur_active && cur_off && (!rel_found || (cur_age > rel_age))) begin
                rel_found <= 1'b1;
                rel_idx   <= scan_idx;
                rel_age   <= cur_age;
            end
            if (cur_active && !cur_off && (!act_found || (cur_age > act_age))) begin
                act_found <= 1'b1;
                act_idx   <= scan_idx;
                act_age   <= cur_age;
            end
        end
    end

    // Commit decision: apply the priority order to the scan results.
    always_comb begin
        commit_on_vec  = '0;
        commit_off_vec = '0;
        steal          = 1'b0;
        chosen         = match_idx;
        if (state == COMMIT) begin
            if (ev_on) begin
                if (match_found) begin
                    chosen = match_idx;
                end else if (free_found) begin
                    chosen = free_idx;
                end else if (rel_found) begin
                    chosen = rel_idx;
                end else begin
                    chosen = act_idx;
                    steal  = 1'b1;
                end
                commit_on_vec[chosen] = 1'b1;
            end else if (match_found) begin
                commit_off_vec[match_idx] = 1'b1;
            end
        end
    end

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            voice_slot #(
                .NOTE_W (NOTE_W),
                .VEL_W  (VEL_W),
                .AGE_W  (AGE_W)
            ) u_slot (
                .clk        (Clk),
                .rst        (Reset),
                .commit_on  (commit_on_vec[v]),
                .commit_off (commit_off_vec[v]),
                .age_inc    ((|commit_on_vec) & ~commit_on_vec[v]),
                .env_idle   (envIdle[v]),
                .ev_note    (ev_note),
                .ev_vel     (ev_vel),
                .trig       (Trig[v]),
                .active     (voiceActive[v]),
                .note_off   (noteOff[v]),
                .note       (notes[v]),
                .vel        (voiceVel[v*VEL_W +: VEL_W]),
                .age        (ages[v])
            );
            assign voiceNote[v*NOTE_W +: NOTE_W] = notes[v];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Self-checking bench: directed scenarios plus random events
//               against a behavioural voice-pool model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int N    = 4;
    localparam int NW   = 7;
    localparam int VW   = 7;
    localparam int AW   = 3;
    localparam int AMAX = 7;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            evValid;
    logic            evReady;
    logic            evNoteOn;
    logic [NW-1:0]   evNote;
    logic [VW-1:0]   evVel;
    logic [N-1:0]    envIdle;
    logic [N-1:0]    Trig;
    logic [N-1:0]    noteOff;
    logic [N-1:0]    voiceActive;
    logic [N*NW-1:0] voiceNote;
    logic [N*VW-1:0] voiceVel;
    logic            stolen;

    voice_allocator #(
        .NUM_VOICES (N),
        .NOTE_W     (NW),
        .VEL_W      (VW),
        .AGE_W      (AW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .evValid     (evValid),
        .evReady     (evReady),
        .evNoteOn    (evNoteOn),
        .evNote      (evNote),
        .evVel       (evVel),
        .envIdle     (envIdle),
        .Trig        (Trig),
        .noteOff     (noteOff),
        .voiceActive (voiceActive),
        .voiceNote   (voiceNote),
        .voiceVel    (voiceVel),
        .stolen      (stolen)
    );

    always #5 Clk = ~Clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Behavioural voice pool
    bit m_active [N];
    bit m_off    [N];
    int m_note   [N];
    int m_vel    [N];
    int m_age    [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0; m_off[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_free(input logic [N-1:0] env);
        for (int i = 0; i < N; i++) begin
            if (m_active[i] && m_off[i] && env[i]) begin
                m_active[i] = 0;
                m_off[i]    = 0;
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [N-1:0]    ea, eo;
        logic [N*NW-1:0] en;
        logic [N*VW-1:0] ev;
        for (int i = 0; i < N; i++) begin
            ea[i] = m_active[i];
            eo[i] = m_off[i];
            en[i*NW +: NW] = NW'(m_note[i]);
            ev[i*VW +: VW] = VW'(m_vel[i]);
        end
        chk({tag, ":active"}, 64'(voiceActive), 64'(ea));
        chk({tag, ":noteOff"}, 64'(noteOff), 64'(eo));
        chk({tag, ":note"}, 64'(voiceNote), 64'(en));
        chk({tag, ":vel"}, 64'(voiceVel), 64'(ev));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; evValid = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst:outs", 64'({evReady, Trig, noteOff, voiceActive, stolen}), 64'd0);
        chk("rst:notevel", 64'({voiceNote, voiceVel}), 64'd0);
        Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        chk("rst:ready_after", 64'(evReady), 64'd1);
    endtask

    task automatic set_env(input logic [N-1:0] e, input string tag);
        @(negedge Clk);
        envIdle = e;
        model_free(e);
        @(negedge Clk);
        check_state(tag);
    endtask

    // Issue one event, update the model by the allocation rules, and check
    // latency, busy window, commit outputs and the cycle after commit.
    task automatic do_event(input bit on, input int note, input int vel, input string tag,
                            output logic [N-1:0] o_trig, output logic o_stolen);
        int            waited;
        int            v;
        int            best;
        bit            on_eff;
        logic [N-1:0]  exp_trig;
        bit            exp_st;
        waited = 0;
        @(negedge Clk);
        while (evReady !== 1'b1 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        chk({tag, ":ready"}, 64'(evReady), 64'd1);
        evValid = 1'b1; evNoteOn = on; evNote = NW'(note); evVel = VW'(vel);
        @(posedge Clk);
        #1;
        evValid = 1'b0; evNoteOn = 1'($urandom); evNote = NW'($urandom); evVel = VW'($urandom);

        exp_trig = '0; exp_st = 0; v = -1;
        on_eff = on && (vel != 0);
        if (on_eff) begin
            for (int i = 0; i < N; i++) if (v < 0 && m_active[i] && m_note[i] == note) v = i;
            for (int i = 0; i < N; i++) if (v < 0 && !m_active[i]) v = i;
            if (v < 0) begin
                best = -1;
                for (int i = 0; i < N; i++)
                    if (m_active[i] && m_off[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
                v = best;
            end
            if (v < 0) begin
                best = -1;
                for (int i = 0; i < N; i++)
                    if (m_active[i] && !m_off[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
                v = best;
                exp_st = 1;
            end
            for (int i = 0; i < N; i++)
                if (i != v && m_active[i] && m_age[i] < AMAX) m_age[i]++;
            m_active[v] = 1; m_off[v] = 0; m_note[v] = note; m_vel[v] = vel; m_age[v] = 0;
            exp_trig[v] = 1'b1;
        end else begin
            for (int i = 0; i < N; i++)
                if (v < 0 && m_active[i] && !m_off[i] && m_note[i] == note) v = i;
            if (v >= 0) m_off[v] = 1;
        end

        for (int k = 0; k < N + 1; k++) begin
            @(negedge Clk);
            chk({tag, ":busy"}, 64'({evReady, Trig, stolen}), 64'd0);
        end
        @(negedge Clk);
        o_trig = Trig; o_stolen = stolen;
        chk({tag, ":trig"}, 64'(Trig), 64'(exp_trig));
        chk({tag, ":stolen"}, 64'(stolen), 64'(exp_st));
        chk({tag, ":ready_back"}, 64'(evReady), 64'd1);
        check_state({tag, ":commit"});
        model_free(envIdle);
        @(negedge Clk);
        chk({tag, ":pulse_end"}, 64'({Trig, stolen}), 64'd0);
        check_state({tag, ":after"});
    endtask

    initial begin
        logic [N-1:0] t;
        logic         s;
        Reset = 1'b1; evValid = 1'b0; evNoteOn = 1'b0; evNote = '0; evVel = '0; envIdle = '0;
        model_reset();

        // Single note-on: latency and payload
        do_reset();
        do_event(1, 60, 100, "on60", t, s);
        chk("on60:trig_v0", 64'(t), 64'b0001);
        chk("on60:note_v0", 64'(voiceNote[NW-1:0]), 64'd60);
        chk("on60:vel_v0", 64'(voiceVel[VW-1:0]), 64'd100);

        // Fill all voices then steal the oldest
        do_reset();
        do_event(1, 60, 10, "fill0", t, s);
        do_event(1, 62, 20, "fill1", t, s);
        do_event(1, 64, 30, "fill2", t, s);
        do_event(1, 66, 40, "fill3", t, s);
        do_event(1, 67, 50, "steal", t, s);
        chk("steal:trig_v0", 64'(t), 64'b0001);
        chk("steal:pulse", 64'(s), 64'd1);
        chk("steal:note_v0", 64'(voiceNote[NW-1:0]), 64'd67);

        // Release held until the envelope goes idle
        do_reset();
        do_event(1, 60, 90, "rel_on", t, s);
        do_event(0, 60, 0, "rel_off", t, s);
        repeat (20) @(negedge Clk);
        chk("rel:held", 64'({voiceActive[0], noteOff[0]}), 64'b11);
        set_env(4'b0001, "rel_free");
        chk("rel:cleared", 64'({voiceActive[0], noteOff[0]}), 64'b00);
        chk("rel:note_hold", 64'(voiceNote[NW-1:0]), 64'd60);
        set_env(4'b0000, "rel_env0");

        // Releasing voice preferred over stealing
        do_reset();
        do_event(1, 60, 1, "pr0", t, s);
        do_event(1, 62, 2, "pr1", t, s);
        do_event(1, 64, 3, "pr2", t, s);
        do_event(1, 66, 4, "pr3", t, s);
        do_event(0, 64, 5, "pr_off", t, s);
        do_event(1, 70, 6, "pr_on70", t, s);
        chk("pr:trig_v2", 64'(t), 64'b0100);
        chk("pr:no_steal", 64'(s), 64'd0);
        chk("pr:off2_clr", 64'(noteOff[2]), 64'd0);

        // Retrigger of a playing note; velocity-0 note-off with no match
        do_reset();
        do_event(1, 60, 50, "rt1", t, s);
        do_event(1, 60, 70, "rt2", t, s);
        chk("rt:trig_v0", 64'(t), 64'b0001);
        chk("rt:v1_idle", 64'(voiceActive[1]), 64'd0);
        do_event(1, 61, 0, "vel0", t, s);
        chk("vel0:no_trig", 64'(t), 64'd0);

        // Reset in the middle of a scan
        do_reset();
        @(negedge Clk);
        evValid = 1'b1; evNoteOn = 1'b1; evNote = 7'd64; evVel = 7'd90;
        @(posedge Clk);
        #1;
        evValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid:outs", 64'({evReady, Trig, noteOff, voiceActive, stolen}), 64'd0);
        chk("mid:notevel", 64'({voiceNote, voiceVel}), 64'd0);
        Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        chk("mid:ready", 64'(evReady), 64'd1);
        for (int k = 0; k < N + 3; k++) begin
            @(negedge Clk);
            chk("mid:quiet", 64'({Trig, voiceActive}), 64'd0);
        end

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 120; it++) begin
            set_env(N'($urandom & $urandom), "rnd_env");
            do_event(($urandom_range(0, 2) != 0),
                     60 + $urandom_range(0, 5),
                     ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127),
                     "rnd", t, s);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
